// File: rtl/vecmat32_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vecmat32_seq
// Purpose  : Sequencer / result collector for the 32-lane vector-matrix
//            datapath. Assembles the softmax vector from an element stream,
//            streams V columns into the datapath under a credit limit, and
//            returns each dot-product result on a ready/valid stream.
// Revision : 1.0 - initial release
// ============================================================================
module vecmat32_seq #(
    parameter int LANES      = 32,
    parameter int DW         = 16,
    parameter int NUM_COLS   = 64,
    parameter int DP_LATENCY = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [DW-1:0]         vec_data,
    input  logic                  mat_valid,
    output logic                  mat_ready,
    input  logic [LANES*DW-1:0]   mat_data,
    output logic [LANES*DW-1:0]   vector_out,
    output logic [LANES*DW-1:0]   matrix_out,
    input  logic [DW-1:0]         dp_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DW-1:0]         res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_ELEM_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_ELEM_W-1:0] c_LAST_ELEM = c_ELEM_W'(LANES - 1);
    localparam logic [c_COL_W-1:0]  c_LAST_COL  = c_COL_W'(NUM_COLS - 1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PTR  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W:0]    c_DEPTH     = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_VEC = 2'd1,
        S_STREAM   = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_ELEM_W-1:0]    r_elem_cnt;
    logic [c_COL_W-1:0]     r_col_cnt;
    logic [c_CNT_W-1:0]     r_inflight;
    logic [c_CNT_W-1:0]     r_fifo_count;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [DW:0]            r_fifo_mem [FIFO_DEPTH];
    logic [DP_LATENCY:0]    r_dl_valid;
    logic [DP_LATENCY:0]    r_dl_last;
    logic [LANES*DW-1:0]    r_vector;
    logic [LANES*DW-1:0]    r_matrix;

    logic                   w_vec_accept;
    logic                   w_mat_accept;
    logic                   w_credit_ok;
    logic                   w_capture;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic                   w_drained;
    logic [DW:0]            w_head;

    // Credits count both queued results and results still inside the
    // datapath, so a capture always finds a free FIFO slot.
    assign w_credit_ok  = ({1'b0, r_fifo_count} + {1'b0, r_inflight}) < c_DEPTH;
    assign w_vec_accept = vec_valid && vec_ready;
    assign w_mat_accept = mat_valid && mat_ready;
    assign w_capture    = r_dl_valid[DP_LATENCY];
    assign w_fifo_empty = (r_fifo_count == '0);
    assign w_pop        = !w_fifo_empty && res_ready;
    assign w_drained    = (r_inflight == '0) && w_fifo_empty;
    assign w_head       = r_fifo_mem[r_rd_ptr];

    assign vector_out = r_vector;
    assign matrix_out = r_matrix;
    assign res_valid  = !w_fifo_empty;
    assign res_data   = w_fifo_empty ? '0 : w_head[DW-1:0];
    assign res_last   = w_fifo_empty ? 1'b0 : w_head[DW];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        vec_ready    = 1'b0;
        mat_ready    = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_LOAD_VEC;
            end
            S_LOAD_VEC: begin
                vec_ready = 1'b1;
                if (vec_valid && (r_elem_cnt == c_LAST_ELEM)) w_state_next = S_STREAM;
            end
            S_STREAM: begin
                mat_ready = w_credit_ok;
                if (mat_valid && w_credit_ok && (r_col_cnt == c_LAST_COL)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drained) begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Element / column counters, vector assembly and column register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elem_cnt <= '0;
            r_col_cnt  <= '0;
            r_vector   <= '0;
            r_matrix   <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_elem_cnt <= '0;
                r_col_cnt  <= '0;
            end
            if (w_vec_accept) begin
                r_vector[r_elem_cnt*DW +: DW] <= vec_data;
                r_elem_cnt                    <= r_elem_cnt + 1'b1;
            end
            if (w_mat_accept) begin
                r_matrix  <= mat_data;
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Delay line tracking which datapath outputs belong to accepted columns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dl_valid <= '0;
            r_dl_last  <= '0;
        end else begin
            r_dl_valid <= {r_dl_valid[DP_LATENCY-1:0], w_mat_accept};
            r_dl_last  <= {r_dl_last[DP_LATENCY-1:0], w_mat_accept && (r_col_cnt == c_LAST_COL)};
        end
    end

    // In-flight counter: accept adds, capture removes, both together cancel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_mat_accept, w_capture})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_capture) r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_capture, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Result storage; contents are only observed while occupancy marks them live
    always_ff @(posedge clk) begin
        if (w_capture) r_fifo_mem[r_wr_ptr] <= {r_dl_last[DP_LATENCY], dp_result};
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_capture && !w_pop && (r_fifo_count == c_DEPTH_CNT)));

endmodule
`default_nettype wire
